// File: rtl/servant_power_ctrl_if.sv
// Sleep/wake control bundle between the SoC power manager and the sequencer.
// The master drives requests and wake sources; the slave is the sequencer itself.
interface servant_power_ctrl_if #(
  parameter int N_WAKE  = 4,
  parameter int TIMER_W = 16
);
  logic               i_sleep_req;
  logic [TIMER_W-1:0] i_sleep_ticks;
  logic [N_WAKE-1:0]  i_wake;
  logic [N_WAKE-1:0]  i_wake_mask;
  logic               i_core_idle;
  logic               o_hf_en;
  logic               o_core_hold;
  logic               o_sleeping;
  logic               o_wake;
  logic               o_abort;
  logic [N_WAKE:0]    o_wake_cause;

  modport master (
    output i_sleep_req, i_sleep_ticks, i_wake, i_wake_mask, i_core_idle,
    input  o_hf_en, o_core_hold, o_sleeping, o_wake, o_abort, o_wake_cause
  );

  modport slave (
    input  i_sleep_req, i_sleep_ticks, i_wake, i_wake_mask, i_core_idle,
    output o_hf_en, o_core_hold, o_sleeping, o_wake, o_abort, o_wake_cause
  );
endinterface

// File: rtl/servant_power_ctrl.sv
// Always-on sleep/wake sequencer: drains the core, gates the HF oscillator,
// times the sleep interval and holds the core until the HF clock has settled.
module servant_power_ctrl #(
  parameter int N_WAKE        = 4,
  parameter int TIMER_W       = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  servant_power_ctrl_if.slave  bus
);

  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SLEEP,
    ST_SETTLE
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [SCW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [N_WAKE:0]    cause_q, cause_d;
  logic               abort_q, abort_d;
  logic               wake_q, wake_d;
  logic               hf_en_q, hf_en_d;
  logic               core_hold_q, core_hold_d;
  logic               sleeping_q, sleeping_d;
  logic [N_WAKE-1:0]  pend_bits;
  logic               pend;
  logic               timer_fire;

  always_comb begin
    pend_bits    = bus.i_wake & bus.i_wake_mask;
    pend         = |pend_bits;
    timer_fire   = (timer_q == TIMER_W'(1));
    state_d      = state_q;
    timer_d      = timer_q;
    drain_cnt_d  = drain_cnt_q;
    settle_cnt_d = settle_cnt_q;
    cause_d      = cause_q;
    abort_d      = 1'b0;
    wake_d       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.i_sleep_req) begin
          // With no timer and no enabled source the core could never wake.
          if ((bus.i_sleep_ticks != '0) || (bus.i_wake_mask != '0)) begin
            timer_d     = bus.i_sleep_ticks;
            cause_d     = '0;
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end else begin
            abort_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (pend) begin
          cause_d = {1'b0, pend_bits};
          abort_d = 1'b1;
          state_d = ST_RUN;
        end else if (bus.i_core_idle) begin
          state_d = ST_SLEEP;
        end else if (drain_cnt_q == DCW'(DRAIN_TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = ST_RUN;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      ST_SLEEP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end
        if (pend || timer_fire) begin
          cause_d      = {timer_fire, pend_bits};
          timer_d      = '0;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) begin
          wake_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + SCW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Level outputs are decoded from the next state so they register in step with it.
    hf_en_d     = (state_d != ST_SLEEP);
    core_hold_d = (state_d != ST_RUN);
    sleeping_d  = (state_d == ST_SLEEP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_RUN;
      timer_q      <= '0;
      drain_cnt_q  <= '0;
      settle_cnt_q <= '0;
      cause_q      <= '0;
      abort_q      <= 1'b0;
      wake_q       <= 1'b0;
      hf_en_q      <= 1'b1;
      core_hold_q  <= 1'b0;
      sleeping_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      drain_cnt_q  <= drain_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      cause_q      <= cause_d;
      abort_q      <= abort_d;
      wake_q       <= wake_d;
      hf_en_q      <= hf_en_d;
      core_hold_q  <= core_hold_d;
      sleeping_q   <= sleeping_d;
    end
  end

  assign bus.o_hf_en      = hf_en_q;
  assign bus.o_core_hold  = core_hold_q;
  assign bus.o_sleeping   = sleeping_q;
  assign bus.o_wake       = wake_q;
  assign bus.o_abort      = abort_q;
  assign bus.o_wake_cause = cause_q;

endmodule

// File: tb/tb_servant_power_ctrl.sv
// Directed bench for servant_power_ctrl: a phase-level reference model is compared
// every cycle, and each scenario also pins hand-computed counts and cause values.
module tb_servant_power_ctrl;

  localparam int N_WAKE        = 4;
  localparam int TIMER_W       = 16;
  localparam int SETTLE_CYCLES = 2;
  localparam int DRAIN_TIMEOUT = 8;

  localparam int P_RUN    = 0;
  localparam int P_DRAIN  = 1;
  localparam int P_SLEEP  = 2;
  localparam int P_SETTLE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  servant_power_ctrl_if #(.N_WAKE(N_WAKE), .TIMER_W(TIMER_W)) bus ();

  servant_power_ctrl #(
    .N_WAKE(N_WAKE),
    .TIMER_W(TIMER_W),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  int sleep_cnt = 0;
  int hold_cnt  = 0;
  int wake_cnt  = 0;
  int abort_cnt = 0;
  int hf_low    = 0;

  // Reference model: phase plus "cycles spent / cycles left" bookkeeping.
  int              m_phase = P_RUN;
  int              m_drained = 0;
  int              m_settle_left = 0;
  int              m_timer = 0;
  logic [N_WAKE:0] m_cause = '0;
  bit              m_hf_en = 1, m_hold = 0, m_sleeping = 0, m_wake = 0, m_abort = 0;
  logic [N_WAKE-1:0] m_hits;
  bit              m_fire;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit req, input int ticks, input logic [N_WAKE-1:0] mask,
                               input logic [N_WAKE-1:0] wake, input bit idle);
    bus.i_sleep_req   = req;
    bus.i_sleep_ticks = TIMER_W'(ticks);
    bus.i_wake_mask   = mask;
    bus.i_wake        = wake;
    bus.i_core_idle   = idle;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearCounters();
    sleep_cnt = 0; hold_cnt = 0; wake_cnt = 0; abort_cnt = 0; hf_low = 0;
  endtask

  task automatic waitFor(input int which, input string name);
    bit hit = 0;
    for (int n = 0; n < 60 && !hit; n++) begin
      @(negedge clk);
      case (which)
        0: hit = bus.o_sleeping;
        1: hit = bus.o_wake;
        default: hit = bus.o_abort;
      endcase
    end
    checkOutput(name, 32'(hit), 32'd1);
  endtask

  always @(posedge clk) begin
    m_hits  = bus.i_wake & bus.i_wake_mask;
    m_wake  = 0;
    m_abort = 0;
    if (rst) begin
      m_phase = P_RUN;
      m_timer = 0;
      m_cause = '0;
    end else begin
      case (m_phase)
        P_RUN: if (bus.i_sleep_req) begin
          if (bus.i_sleep_ticks != 0 || bus.i_wake_mask != 0) begin
            m_timer   = int'(bus.i_sleep_ticks);
            m_cause   = '0;
            m_drained = 0;
            m_phase   = P_DRAIN;
          end else m_abort = 1;
        end
        P_DRAIN: begin
          m_drained++;
          if (m_hits != 0) begin
            m_cause = {1'b0, m_hits};
            m_abort = 1;
            m_phase = P_RUN;
          end else if (bus.i_core_idle) m_phase = P_SLEEP;
          else if (m_drained == DRAIN_TIMEOUT) begin
            m_abort = 1;
            m_phase = P_RUN;
          end
        end
        P_SLEEP: begin
          m_fire = (m_timer == 1);
          if (m_timer > 0) m_timer--;
          if (m_fire || m_hits != 0) begin
            m_cause       = {m_fire, m_hits};
            m_settle_left = SETTLE_CYCLES;
            m_phase       = P_SETTLE;
          end
        end
        default: begin
          m_settle_left--;
          if (m_settle_left == 0) begin
            m_wake  = 1;
            m_phase = P_RUN;
          end
        end
      endcase
    end
    m_hf_en    = (m_phase != P_SLEEP);
    m_hold     = (m_phase != P_RUN);
    m_sleeping = (m_phase == P_SLEEP);
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cycle_outputs",
                  32'({bus.o_hf_en, bus.o_core_hold, bus.o_sleeping, bus.o_wake, bus.o_abort, bus.o_wake_cause}),
                  32'({m_hf_en, m_hold, m_sleeping, m_wake, m_abort, m_cause}));
      if (bus.o_sleeping)  sleep_cnt++;
      if (bus.o_core_hold) hold_cnt++;
      if (bus.o_wake)      wake_cnt++;
      if (bus.o_abort)     abort_cnt++;
      if (!bus.o_hf_en)    hf_low++;
    end
  end

  initial begin
    applyStimulus(0, 0, 4'b0000, 4'b0000, 1);
    rst = 1;
    step(3);
    rst = 0;
    checking = 1;
    $display("[TB] reset values");
    checkOutput("reset_hf_en", 32'(bus.o_hf_en), 32'd1);
    checkOutput("reset_others",
                32'({bus.o_core_hold, bus.o_sleeping, bus.o_wake, bus.o_abort, bus.o_wake_cause}), 32'd0);

    $display("[TB] timer wake ticks=5");
    step(1); clearCounters();
    applyStimulus(1, 5, 4'b0000, 4'b0000, 1);
    step(1);
    applyStimulus(0, 5, 4'b0000, 4'b0000, 1);
    waitFor(1, "timer_wake_seen");
    step(2);
    checkOutput("timer_sleep_len", sleep_cnt, 5);
    checkOutput("timer_hold_len", hold_cnt, 8);
    checkOutput("timer_wake_pulses", wake_cnt, 1);
    checkOutput("timer_cause", 32'(bus.o_wake_cause), 32'b10000);

    $display("[TB] external wake on sleep cycle 3");
    clearCounters();
    applyStimulus(1, 0, 4'b0010, 4'b0000, 1);
    step(1);
    applyStimulus(0, 0, 4'b0010, 4'b0000, 1);
    waitFor(0, "ext_sleep_seen");
    step(2);
    applyStimulus(0, 0, 4'b0010, 4'b0010, 1);
    step(1);
    checkOutput("ext_settle_hf_en", 32'({bus.o_hf_en, bus.o_sleeping, bus.o_core_hold}), 32'b101);
    applyStimulus(0, 0, 4'b0010, 4'b0000, 1);
    waitFor(1, "ext_wake_seen");
    step(2);
    checkOutput("ext_sleep_len", sleep_cnt, 3);
    checkOutput("ext_cause", 32'(bus.o_wake_cause), 32'b00010);

    $display("[TB] simultaneous timer and wake[0]");
    clearCounters();
    applyStimulus(1, 4, 4'b0001, 4'b0000, 1);
    step(1);
    applyStimulus(0, 4, 4'b0001, 4'b0000, 1);
    waitFor(0, "sim_sleep_seen");
    step(3);
    applyStimulus(0, 4, 4'b0001, 4'b0001, 1);
    step(1);
    applyStimulus(0, 4, 4'b0001, 4'b0000, 1);
    waitFor(1, "sim_wake_seen");
    step(4);
    checkOutput("sim_sleep_len", sleep_cnt, 4);
    checkOutput("sim_wake_pulses", wake_cnt, 1);
    checkOutput("sim_cause", 32'(bus.o_wake_cause), 32'b10001);

    $display("[TB] drain timeout");
    clearCounters();
    applyStimulus(1, 3, 4'b0000, 4'b0000, 0);
    step(1);
    applyStimulus(0, 3, 4'b0000, 4'b0000, 0);
    waitFor(2, "timeout_abort_seen");
    step(2);
    checkOutput("timeout_drain_len", hold_cnt, DRAIN_TIMEOUT);
    checkOutput("timeout_hf_low", hf_low, 0);
    checkOutput("timeout_abort_pulses", abort_cnt, 1);
    checkOutput("timeout_cause", 32'(bus.o_wake_cause), 32'd0);

    $display("[TB] pending wake at request");
    clearCounters();
    applyStimulus(1, 0, 4'b0100, 4'b0100, 1);
    step(1);
    applyStimulus(0, 0, 4'b0100, 4'b0100, 1);
    step(1);
    applyStimulus(0, 0, 4'b0100, 4'b0000, 1);
    step(2);
    checkOutput("pend_drain_len", hold_cnt, 1);
    checkOutput("pend_abort_pulses", abort_cnt, 1);
    checkOutput("pend_sleep", sleep_cnt, 0);
    checkOutput("pend_cause", 32'(bus.o_wake_cause), 32'b00100);

    $display("[TB] reject with no wake source");
    clearCounters();
    applyStimulus(1, 0, 4'b0000, 4'b0000, 1);
    step(1);
    applyStimulus(0, 0, 4'b0000, 4'b0000, 1);
    step(3);
    checkOutput("reject_abort_pulses", abort_cnt, 1);
    checkOutput("reject_hold", hold_cnt, 0);
    checkOutput("reject_cause_kept", 32'(bus.o_wake_cause), 32'b00100);

    $display("[TB] back-to-back request");
    clearCounters();
    applyStimulus(1, 2, 4'b0000, 4'b0000, 1);
    waitFor(1, "b2b_first_wake");
    step(1);
    checkOutput("b2b_hold", 32'(bus.o_core_hold), 32'd1);
    applyStimulus(0, 2, 4'b0000, 4'b0000, 1);
    waitFor(1, "b2b_second_wake");
    step(2);
    checkOutput("b2b_wake_pulses", wake_cnt, 2);

    $display("[TB] reset during sleep");
    applyStimulus(1, 100, 4'b0000, 4'b0000, 1);
    step(1);
    applyStimulus(0, 100, 4'b0000, 4'b0000, 1);
    waitFor(0, "rst_sleep_seen");
    step(3);
    rst = 1;
    step(1);
    rst = 0;
    checkOutput("rst_mid_sleep",
                32'({bus.o_hf_en, bus.o_core_hold, bus.o_sleeping, bus.o_wake, bus.o_abort, bus.o_wake_cause}),
                32'b1000000000);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
